serial_subtractor: RTL and testbench

Bit-serial multi-bit subtractor built around a 1-bit full-subtractor cell plus a registered borrow.
- Accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake.
- Processes one bit per clock, LSB first.
- Presents difference and borrow-out through a valid/ready output handshake.
- Sits between the operand source and the result consumer; this is the sequential stage that drives the full-subtractor cell.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 34 +++
 rtl/serial_subtractor_full_sub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and width helper for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold values 0..WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_sub_cell.sv
// 1-bit full subtractor: d = x - y - z, b = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic b
);

  assign d = x ^ y ^ z;
  assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock through full_sub_cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_q;
  logic             z;
  logic             bout_q;
  logic             d;
  logic             bo;
  logic             last;
  logic             in_ready;
  logic             out_valid;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  full_sub_cell u_cell (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .z (z),
    .d (d),
    .b (bo)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Results update only on the final shift edge so they hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      diff_q  <= '0;
      z       <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            z       <= bus.bin;
            cnt     <= '0;
            diff_sr <= '0;
          end
        end
        ST_SHIFT: begin
          diff_sr <= {d, diff_sr[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          z       <= bo;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            diff_q <= {d, diff_sr[WIDTH-1:1]};
            bout_q <= bo;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB (z) differing from borrow out flags signed overflow.
            ovf_q  <= z ^ bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances).
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(2)) if2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input int w, input int a, input int b, input int bin,
                       output int e_diff, output int e_bout, output int e_ovf);
    int r, sa, sb, s, half;
    half   = 1 << (w - 1);
    r      = a - b - bin;
    e_diff = r & ((1 << w) - 1);
    e_bout = (r < 0) ? 1 : 0;
    sa     = (a >= half) ? a - (1 << w) : a;
    sb     = (b >= half) ? b - (1 << w) : b;
    s      = sa - sb - bin;
    e_ovf  = (s < -half || s > half - 1) ? 1 : 0;
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int hold);
    int lat, e_diff, e_bout, e_ovf;
    model(8, int'(a), int'(b), int'(bin), e_diff, e_bout, e_ovf);
    @(negedge clk);
    chk("w8_in_ready_idle", 32'(if8.in_ready), 32'd1);
    if8.a = a; if8.b = b; if8.bin = bin; if8.in_valid = 1'b1;
    if8.out_ready = (hold == 0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    chk("w8_in_ready_busy", 32'(if8.in_ready), 32'd0);
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_diff", 32'(if8.diff), 32'(e_diff));
    chk("w8_bout", 32'(if8.bout), 32'(e_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk("w8_ovf", 32'(if8.ovf), 32'(e_ovf));
`endif
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = ~if8.in_valid;
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      @(negedge clk);
      chk("w8_hold_valid", 32'(if8.out_valid), 32'd1);
      chk("w8_hold_ready", 32'(if8.in_ready), 32'd0);
      chk("w8_hold_diff", 32'(if8.diff), 32'(e_diff));
      chk("w8_hold_bout", 32'(if8.bout), 32'(e_bout));
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(negedge clk);
    chk("w8_post_valid", 32'(if8.out_valid), 32'd0);
    chk("w8_post_ready", 32'(if8.in_ready), 32'd1);
    chk("w8_post_diff", 32'(if8.diff), 32'(e_diff));
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    int lat, e_diff, e_bout, e_ovf;
    model(2, int'(a), int'(b), int'(bin), e_diff, e_bout, e_ovf);
    @(negedge clk);
    if2.a = a; if2.b = b; if2.bin = bin; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0;
    lat = 0;
    while (!if2.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w2_latency", 32'(lat), 32'd2);
    chk("w2_diff", 32'(if2.diff), 32'(e_diff));
    chk("w2_bout", 32'(if2.bout), 32'(e_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk("w2_ovf", 32'(if2.ovf), 32'(e_ovf));
`endif
    @(negedge clk);
    chk("w2_post_ready", 32'(if2.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.bin = 1'b0; if2.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_diff", 32'(if8.diff), 32'd0);
    chk("rst_bout", 32'(if8.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(if8.ovf), 32'd0);
`endif
    rst = 1'b0;

    // Directed cases
    run_op8(8'h05, 8'h03, 1'b0, 0);
    run_op8(8'h03, 8'h05, 1'b0, 0);
    run_op8(8'h00, 8'h00, 1'b1, 0);
    run_op8(8'hA0, 8'h0F, 1'b0, 5);
    run_op8(8'h80, 8'h01, 1'b0, 0);
    run_op8(8'h7F, 8'h01, 1'b0, 0);

    // Reset mid-SHIFT with a pending borrow, then a clean operation
    @(negedge clk);
    if8.a = 8'h00; if8.b = 8'hFF; if8.bin = 1'b1; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("midrst_diff", 32'(if8.diff), 32'd0);
    chk("midrst_bout", 32'(if8.bout), 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("midrst_no_output", 32'(if8.out_valid), 32'd0);
    end
    run_op8(8'h10, 8'h01, 1'b0, 0);

    // Random operands with random backpressure
    for (int i = 0; i < 25; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Exhaustive WIDTH=2
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run_op2(2'(a), 2'(b), 1'(c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
